pipelined_control: RTL

Parametrised next-generation main control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode into the control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and generates stall and bubble signals, applies branch/jump flushes, and keeps a saturating stall counter. It sits beside the datapath's pipeline registers and replaces the purely combinational decoder plus the ad-hoc control fields in those registers.

---
 rtl/control_pkg.sv | 84 ++++++++
 rtl/control_decode.sv | 79 +++++++
 rtl/pipelined_control.sv | 119 +++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared opcode constants, control-field encodings and stage bundle types
// for the pipelined MIPS main control unit.
package control_pkg;

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_BCOND    = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;
   localparam logic [5:0] OP_IMM_LO   = 6'b001000;
   localparam logic [5:0] OP_IMM_HI   = 6'b001111;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
   localparam logic [5:0] OP_LB       = 6'b100000;
   localparam logic [5:0] OP_LH       = 6'b100001;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SB       = 6'b101000;
   localparam logic [5:0] OP_SH       = 6'b101001;
   localparam logic [5:0] OP_SW       = 6'b101011;

   localparam logic [1:0] MTR_ALU  = 2'b00;
   localparam logic [1:0] MTR_WORD = 2'b01;
   localparam logic [1:0] MTR_BYTE = 2'b10;
   localparam logic [1:0] MTR_HALF = 2'b11;

   localparam logic [1:0] SM_WORD = 2'b00;
   localparam logic [1:0] SM_BYTE = 2'b01;
   localparam logic [1:0] SM_HALF = 2'b10;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   typedef struct packed {
      logic [1:0] reg_dst;
      logic       alu_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] store_mode;
   } mem_ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic       jal_mux_sel;
   } wb_ctrl_t;

   // What survives past EX: carried by the EX/MEM register.
   typedef struct packed {
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } late_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_ZERO = '0;
   localparam late_ctrl_t   LATE_ZERO = '0;

   function automatic logic [1:0] load_mem_to_reg(input logic [5:0] op);
      case (op)
         OP_LB:   return MTR_BYTE;
         OP_LH:   return MTR_HALF;
         default: return MTR_WORD;
      endcase
   endfunction

   function automatic logic [1:0] store_mode_of(input logic [5:0] op);
      case (op)
         OP_SB:   return SM_BYTE;
         OP_SH:   return SM_HALF;
         default: return SM_WORD;
      endcase
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational main decoder: ID-stage opcode to the full EX/MEM/WB bundle
// and the ALUOp field.
module control_decode
   import control_pkg::*;
#(
   parameter int OPC_W   = 6,
   parameter int ALUOP_W = 6
) (
   input  logic [OPC_W-1:0]   opcode,
   output ctrl_bundle_t       bundle,
   output logic [ALUOP_W-1:0] alu_op
);

   logic [OPC_W+5:0]   opc_ext;
   logic [5:0]         op6;
   logic               opc_legal;
   logic               known;
   logic [ALUOP_W-1:0] alu_op_ext;

   // Opcode bits above the 6-bit MIPS field must be zero for a valid decode.
   assign opc_ext   = {6'b000000, opcode};
   assign op6       = opc_ext[5:0];
   assign opc_legal = (opc_ext[OPC_W+5:6] == '0);

   generate
      if (ALUOP_W > OPC_W) begin : g_alu_zext
         assign alu_op_ext = {{(ALUOP_W-OPC_W){1'b0}}, opcode};
      end else begin : g_alu_trunc
         assign alu_op_ext = opcode[ALUOP_W-1:0];
      end
   endgenerate

   always_comb begin
      bundle = CTRL_ZERO;
      alu_op = '0;
      known  = 1'b1;
      case (op6) inside
         OP_RTYPE, OP_SPECIAL3: begin
            bundle.ex.reg_dst   = RD_RD;
            bundle.wb.reg_write = 1'b1;
         end
         OP_BCOND, [OP_BEQ:OP_BGTZ]: begin
            bundle.mem.branch = 1'b1;
         end
         OP_J, OP_SPECIAL2: begin
         end
         OP_JAL: begin
            bundle.ex.reg_dst     = RD_RA;
            bundle.wb.reg_write   = 1'b1;
            bundle.wb.jal_mux_sel = 1'b1;
         end
         [OP_IMM_LO:OP_IMM_HI]: begin
            bundle.ex.reg_dst    = RD_RT;
            bundle.ex.alu_src    = 1'b1;
            bundle.wb.reg_write  = 1'b1;
            bundle.wb.mem_to_reg = MTR_ALU;
         end
         OP_LB, OP_LH, OP_LW: begin
            bundle.ex.alu_src    = 1'b1;
            bundle.wb.reg_write  = 1'b1;
            bundle.mem.mem_read  = 1'b1;
            bundle.wb.mem_to_reg = load_mem_to_reg(op6);
         end
         OP_SB, OP_SH, OP_SW: begin
            bundle.ex.alu_src     = 1'b1;
            bundle.mem.mem_write  = 1'b1;
            bundle.mem.store_mode = store_mode_of(op6);
         end
         default: known = 1'b0;
      endcase

      if (known && opc_legal) begin
         alu_op = alu_op_ext;
      end else begin
         bundle = CTRL_ZERO;
      end
   end

endmodule

// File: rtl/pipelined_control.sv
// Main control unit for the 5-stage pipeline: decodes in ID, carries the
// control bundle through ID/EX, EX/MEM, MEM/WB, with load-use stall and flush.
module pipelined_control
   import control_pkg::*;
#(
   parameter int OPC_W     = 6,
   parameter int ALUOP_W   = 6,
   parameter int REG_W     = 5,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [OPC_W-1:0]   Opcode,
   input  logic [REG_W-1:0]   ID_Rs,
   input  logic [REG_W-1:0]   ID_Rt,
   input  logic [REG_W-1:0]   EX_Rt,
   input  logic               Flush,
   output logic               PCWrite,
   output logic               IFIDWrite,
   output logic               IFIDFlush,
   output logic [1:0]         EX_RegDst,
   output logic               EX_ALUSrc,
   output logic [ALUOP_W-1:0] EX_ALUOp,
   output logic               MEM_MemRead,
   output logic               MEM_MemWrite,
   output logic               MEM_Branch,
   output logic [1:0]         MEM_StoreMode,
   output logic               WB_RegWrite,
   output logic [1:0]         WB_MemtoReg,
   output logic               WB_JalMuxSel,
   output logic [CNT_W-1:0]   StallCount
);

   ctrl_bundle_t       dec_bundle;
   logic [ALUOP_W-1:0] dec_alu_op;

   ctrl_bundle_t       idex_q,        idex_d;
   logic [ALUOP_W-1:0] idex_alu_op_q, idex_alu_op_d;
   late_ctrl_t         exmem_q,       exmem_d;
   wb_ctrl_t           memwb_q,       memwb_d;
   logic [CNT_W-1:0]   cnt_q,         cnt_d;

   logic rt_nonzero;
   logic rt_match;
   logic load_use;
   logic stall;

   control_decode #(
      .OPC_W   (OPC_W),
      .ALUOP_W (ALUOP_W)
   ) u_decode (
      .opcode (Opcode),
      .bundle (dec_bundle),
      .alu_op (dec_alu_op)
   );

   assign rt_nonzero = (EX_Rt != '0);
   assign rt_match   = (EX_Rt == ID_Rs) || (EX_Rt == ID_Rt);
   assign load_use   = HAZARD_EN && idex_q.mem.mem_read && rt_nonzero && rt_match;
   // A flush squashes the dependent instruction anyway, so it never stalls.
   assign stall      = load_use && !Flush;

   always_comb begin
      idex_d        = dec_bundle;
      idex_alu_op_d = dec_alu_op;
      exmem_d.mem   = idex_q.mem;
      exmem_d.wb    = idex_q.wb;
      memwb_d       = exmem_q.wb;
      cnt_d         = cnt_q;

      if (Flush || stall) begin
         idex_d        = CTRL_ZERO;
         idex_alu_op_d = '0;
      end
      if (Flush) begin
         exmem_d = LATE_ZERO;
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         idex_q        <= CTRL_ZERO;
         idex_alu_op_q <= '0;
         exmem_q       <= LATE_ZERO;
         memwb_q       <= '0;
         cnt_q         <= '0;
      end else begin
         idex_q        <= idex_d;
         idex_alu_op_q <= idex_alu_op_d;
         exmem_q       <= exmem_d;
         memwb_q       <= memwb_d;
         cnt_q         <= cnt_d;
      end
   end

   assign PCWrite       = !stall;
   assign IFIDWrite     = !stall;
   assign IFIDFlush     = Flush;

   assign EX_RegDst     = idex_q.ex.reg_dst;
   assign EX_ALUSrc     = idex_q.ex.alu_src;
   assign EX_ALUOp      = idex_alu_op_q;

   assign MEM_MemRead   = exmem_q.mem.mem_read;
   assign MEM_MemWrite  = exmem_q.mem.mem_write;
   assign MEM_Branch    = exmem_q.mem.branch;
   assign MEM_StoreMode = exmem_q.mem.store_mode;

   assign WB_RegWrite   = memwb_q.reg_write;
   assign WB_MemtoReg   = memwb_q.mem_to_reg;
   assign WB_JalMuxSel  = memwb_q.jal_mux_sel;

   assign StallCount    = cnt_q;

endmodule
